// File: rtl/mram_bus_sequencer_pkg.sv
// Shared types and constants for the MRAM bus sequencer.
// Optional feature macro: MRAM_WRITE_VERIFY_EN (adds the VERIFY state).
package mram_pkg;

  localparam int MRAM_ADDR_W = 20;
  localparam int MRAM_DATA_W = 16;

  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_ACCESS_CYC = 3;
  localparam int DEF_HOLD_CYC   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD,
    ST_RESP
`ifdef MRAM_WRITE_VERIFY_EN
    , ST_VERIFY
`endif
  } mram_state_e;

`ifdef MRAM_WRITE_VERIFY_EN
  // Sub-phase of the verify read-back (reuses the setup/access/hold timing)
  typedef enum logic [1:0] {
    VP_SETUP,
    VP_ACCESS,
    VP_HOLD
  } mram_vphase_e;
`endif

  typedef struct packed {
    logic ce_n;
    logic we_n;
    logic oe_n;
    logic lb_n;
    logic ub_n;
  } mram_strobe_t;

  // All strobes deasserted
  localparam mram_strobe_t STROBES_IDLE = 5'b11111;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mram_bus_sequencer_if.sv
// Request/response handshake between the serial-link control stage and the
// MRAM sequencer. master = upstream requester, slave = sequencer.
interface mram_bus_sequencer_if;
  import mram_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [MRAM_ADDR_W-1:0] req_addr;
  logic [MRAM_DATA_W-1:0] req_wdata;
  logic                   rsp_valid;
  logic [MRAM_DATA_W-1:0] rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mram_bus_sequencer_phase_timer.sv
// Loadable down-counter timing one strobe phase. Loaded with the phase length
// on the edge that enters the phase; last_cycle marks the final cycle.
module mram_phase_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last_cycle
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on phase entry, otherwise count down and park at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last_cycle = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mram_bus_sequencer.sv
// Single-access sequencer for an asynchronous 16-bit MRAM.
// Generates CE/WE/OE/LB/UB with setup/access/hold phases, drives the DQ
// output enable and captures read data. All pin outputs are registered and
// are computed from the next state, so they line up with the state register.
// Optional feature macro: MRAM_WRITE_VERIFY_EN (read-back after every write).
module mram_bus_sequencer
  import mram_pkg::*;
#(
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int ACCESS_CYC = DEF_ACCESS_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mram_bus_sequencer_if.slave    bus,
  output logic                   busy,
  output logic [MRAM_ADDR_W-1:0] mram_addr,
  output logic [MRAM_DATA_W-1:0] mram_dq_out,
  output logic                   mram_dq_oe,
  input  logic [MRAM_DATA_W-1:0] mram_dq_in,
  output logic                   mram_ce_n,
  output logic                   mram_we_n,
  output logic                   mram_oe_n,
  output logic                   mram_lb_n,
  output logic                   mram_ub_n
);

  localparam int MAX_PH = max3(SETUP_CYC, ACCESS_CYC, HOLD_CYC);
  localparam int CNT_W  = $clog2(MAX_PH) + 1;

  if (SETUP_CYC < 1) begin : g_bad_setup
    $error("mram_bus_sequencer: SETUP_CYC must be >= 1");
  end
  if (ACCESS_CYC < 2) begin : g_bad_access
    $error("mram_bus_sequencer: ACCESS_CYC must be >= 2");
  end
  if (HOLD_CYC < 1) begin : g_bad_hold
    $error("mram_bus_sequencer: HOLD_CYC must be >= 1");
  end

  mram_state_e state_q, state_d;
`ifdef MRAM_WRITE_VERIFY_EN
  mram_vphase_e vph_q, vph_d;
  logic         err_q, err_d;
`endif

  logic                   ld;
  logic [CNT_W-1:0]       ld_val;
  logic                   last;
  logic                   accept;

  logic                   write_q, write_d;
  logic [MRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [MRAM_DATA_W-1:0] wdata_q, wdata_d;

  mram_strobe_t           strb_q, strb_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [MRAM_DATA_W-1:0] rdata_q, rdata_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;

  // ready_q is only high while idle, so it doubles as the accept qualifier
  assign accept = ready_q & bus.req_valid;

  mram_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ld),
    .load_val  (ld_val),
    .last_cycle(last)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
`ifdef MRAM_WRITE_VERIFY_EN
      vph_q   <= VP_SETUP;
`endif
    end else begin
      state_q <= state_d;
`ifdef MRAM_WRITE_VERIFY_EN
      vph_q   <= vph_d;
`endif
    end
  end

  // Next state and phase-timer reload
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = '0;
`ifdef MRAM_WRITE_VERIFY_EN
    vph_d   = vph_q;
`endif
    case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_SETUP;
        ld      = 1'b1;
        ld_val  = CNT_W'(SETUP_CYC);
      end
      ST_SETUP: if (last) begin
        state_d = ST_ACCESS;
        ld      = 1'b1;
        ld_val  = CNT_W'(ACCESS_CYC);
      end
      ST_ACCESS: if (last) begin
        state_d = ST_HOLD;
        ld      = 1'b1;
        ld_val  = CNT_W'(HOLD_CYC);
      end
      ST_HOLD: if (last) begin
`ifdef MRAM_WRITE_VERIFY_EN
        if (write_q) begin
          state_d = ST_VERIFY;
          vph_d   = VP_SETUP;
          ld      = 1'b1;
          ld_val  = CNT_W'(SETUP_CYC);
        end else begin
          state_d = ST_RESP;
        end
`else
        state_d = ST_RESP;
`endif
      end
      ST_RESP: state_d = ST_IDLE;
`ifdef MRAM_WRITE_VERIFY_EN
      ST_VERIFY: if (last) begin
        case (vph_q)
          VP_SETUP: begin
            vph_d  = VP_ACCESS;
            ld     = 1'b1;
            ld_val = CNT_W'(ACCESS_CYC);
          end
          VP_ACCESS: begin
            vph_d  = VP_HOLD;
            ld     = 1'b1;
            ld_val = CNT_W'(HOLD_CYC);
          end
          default: state_d = ST_RESP;
        endcase
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch: captured once on accept, ignored afterwards
  always_comb begin
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      write_d = bus.req_write;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
    end
  end

  // Pin and response values for the next cycle, derived from the next state
  always_comb begin
    strb_d      = STROBES_IDLE;
    dq_oe_d     = 1'b0;
    rsp_valid_d = (state_d == ST_RESP);
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rdata_d     = rdata_q;
    case (state_d)
      ST_SETUP, ST_HOLD: begin
        strb_d.ce_n = 1'b0;
        strb_d.lb_n = 1'b0;
        strb_d.ub_n = 1'b0;
        dq_oe_d     = write_d;
      end
      ST_ACCESS: begin
        strb_d.ce_n = 1'b0;
        strb_d.lb_n = 1'b0;
        strb_d.ub_n = 1'b0;
        strb_d.we_n = ~write_d;
        strb_d.oe_n = write_d;
        dq_oe_d     = write_d;
      end
`ifdef MRAM_WRITE_VERIFY_EN
      // Read-back: DQ released for the whole replay, setup doubles as turnaround
      ST_VERIFY: begin
        strb_d.ce_n = 1'b0;
        strb_d.lb_n = 1'b0;
        strb_d.ub_n = 1'b0;
        strb_d.oe_n = (vph_d != VP_ACCESS);
      end
`endif
      default: ;
    endcase
    // Sample on the edge that closes the last strobe-low cycle
    if (state_q == ST_ACCESS && last && !write_q)
      rdata_d = mram_dq_in;
`ifdef MRAM_WRITE_VERIFY_EN
    err_d = err_q;
    if (accept)
      err_d = 1'b0;
    if (state_q == ST_VERIFY && vph_q == VP_ACCESS && last) begin
      rdata_d = mram_dq_in;
      err_d   = (mram_dq_in != wdata_q);
    end
`endif
  end

  // Registered request latch, pins and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= STROBES_IDLE;
      dq_oe_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
`ifdef MRAM_WRITE_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      dq_oe_q     <= dq_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
`ifdef MRAM_WRITE_VERIFY_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
`ifdef MRAM_WRITE_VERIFY_EN
  assign bus.rsp_err   = err_q;
`else
  assign bus.rsp_err   = 1'b0;
`endif
  assign busy        = busy_q;
  assign mram_addr   = addr_q;
  assign mram_dq_out = wdata_q;
  assign mram_dq_oe  = dq_oe_q;
  assign mram_ce_n   = strb_q.ce_n;
  assign mram_we_n   = strb_q.we_n;
  assign mram_oe_n   = strb_q.oe_n;
  assign mram_lb_n   = strb_q.lb_n;
  assign mram_ub_n   = strb_q.ub_n;

endmodule

// File: tb/tb_mram_bus_sequencer.sv
// Directed bench for mram_bus_sequencer: default-parameter instance with a
// small MRAM model, plus a 2/4/2 instance for parameterised timing.
// Cycle k is the clock period that ends at edge k (accept edge = edge 0).
module tb_mram_bus_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mram_bus_sequencer_if bus ();
  mram_bus_sequencer_if bus2 ();

  logic        busy, busy2;
  logic [19:0] mram_addr, mram_addr2;
  logic [15:0] mram_dq_out, mram_dq_out2, mram_dq_in, mram_dq_in2;
  logic        mram_dq_oe, mram_dq_oe2;
  logic        mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n;
  logic        ce2, we2, oe2, lb2, ub2;

  mram_bus_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy),
    .mram_addr(mram_addr), .mram_dq_out(mram_dq_out), .mram_dq_oe(mram_dq_oe),
    .mram_dq_in(mram_dq_in), .mram_ce_n(mram_ce_n), .mram_we_n(mram_we_n),
    .mram_oe_n(mram_oe_n), .mram_lb_n(mram_lb_n), .mram_ub_n(mram_ub_n)
  );

  mram_bus_sequencer #(.SETUP_CYC(2), .ACCESS_CYC(4), .HOLD_CYC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2),
    .mram_addr(mram_addr2), .mram_dq_out(mram_dq_out2), .mram_dq_oe(mram_dq_oe2),
    .mram_dq_in(mram_dq_in2), .mram_ce_n(ce2), .mram_we_n(we2),
    .mram_oe_n(oe2), .mram_lb_n(lb2), .mram_ub_n(ub2)
  );

  // MRAM model: 16 words indexed by the low address nibble; flip corrupts bit 0 on store
  logic [15:0] mem [16] = '{default: 16'h0000};
  logic        flip = 1'b0;
  always @(posedge clk)
    if (!mram_ce_n && !mram_we_n)
      mem[mram_addr[3:0]] <= mram_dq_out ^ {15'b0, flip};
  assign mram_dq_in  = mram_oe_n ? 16'h0000 : mem[mram_addr[3:0]];
  assign mram_dq_in2 = oe2 ? 16'h0000 : 16'h5A5A;

`ifdef MRAM_WRITE_VERIFY_EN
  localparam int WLAT = 11;
`else
  localparam int WLAT = 6;
`endif

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [16:0] win(input int lo, input int hi);
    logic [16:0] m;
    m = '0;
    for (int i = 1; i <= 16; i++) if (i >= lo && i <= hi) m[i] = 1'b1;
    return m;
  endfunction

  // Strobe high everywhere except cycles lo..hi
  function automatic logic [16:0] low_in(input int lo, input int hi);
    return ~win(lo, hi) & 17'h1FFFE;
  endfunction

  logic [16:0] tr_ce, tr_we, tr_oe, tr_dqoe, tr_rsp, tr_rdy;
  logic [19:0] c_addr [17];
  logic [15:0] c_dq [17];
  logic [15:0] c_rd [17];
  logic        c_err [17];

  task automatic issue(input logic wr, input logic [19:0] a, input logic [15:0] d, input logic keep);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    #1;
    if (!keep) bus.req_valid = 1'b0;
  endtask

  // Record cycles 1..16 after an accept edge
  task automatic cap(input int drop_at);
    tr_ce = '0; tr_we = '0; tr_oe = '0; tr_dqoe = '0; tr_rsp = '0; tr_rdy = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      tr_ce[c]   = mram_ce_n;
      tr_we[c]   = mram_we_n;
      tr_oe[c]   = mram_oe_n;
      tr_dqoe[c] = mram_dq_oe;
      tr_rsp[c]  = bus.rsp_valid;
      tr_rdy[c]  = bus.req_ready;
      c_addr[c]  = mram_addr;
      c_dq[c]    = mram_dq_out;
      c_rd[c]    = bus.rsp_rdata;
      c_err[c]   = bus.rsp_err;
      if (c == drop_at) bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    int bad_a, bad_d;
    logic [16:0] t2_oe, t2_rsp;
    bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_addr", mram_addr, 0);
    chk("rst_dq_out", mram_dq_out, 0);
    chk("rst_dq_oe", mram_dq_oe, 0);
    chk("rst_strobes", {mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n}, 5'h1F);
    rst_n = 1'b1;

    // Write 0x12345 / 0xBEEF
    issue(1'b1, 20'h12345, 16'hBEEF, 1'b0);
    cap(-1);
    bad_a = 0; bad_d = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c_addr[c] != 20'h12345) bad_a++;
      if (c_dq[c] != 16'hBEEF) bad_d++;
    end
    chk("wr_ce", tr_ce, low_in(1, WLAT - 1));
    chk("wr_we", tr_we, low_in(2, 4));
`ifdef MRAM_WRITE_VERIFY_EN
    chk("wr_oe", tr_oe, low_in(7, 9));
    chk("wr_rdata", c_rd[WLAT], 16'hBEEF);
`else
    chk("wr_oe", tr_oe, 17'h1FFFE);
    chk("wr_rdata_unchanged", c_rd[WLAT], 16'h0000);
`endif
    chk("wr_dqoe", tr_dqoe, win(1, 5));
    chk("wr_rsp", tr_rsp, win(WLAT, WLAT));
    chk("wr_err", c_err[WLAT], 0);
    chk("wr_ready", tr_rdy, win(WLAT + 1, 16));
    chk("wr_addr_hold", bad_a, 0);
    chk("wr_dq_hold", bad_d, 0);
    chk("wr_lb_ub", {mram_lb_n, mram_ub_n}, 2'b11);

    // Read 0x12345, model returns 0xBEEF
    issue(1'b0, 20'h12345, 16'h0000, 1'b0);
    cap(-1);
    chk("rd_ce", tr_ce, low_in(1, 5));
    chk("rd_oe", tr_oe, low_in(2, 4));
    chk("rd_we", tr_we, 17'h1FFFE);
    chk("rd_dqoe", tr_dqoe, 0);
    chk("rd_rsp", tr_rsp, win(6, 6));
    chk("rd_rdata", c_rd[6], 16'hBEEF);
    chk("rd_err", c_err[6], 0);

    // Write with bit 0 corrupted by the model
    flip = 1'b1;
    issue(1'b1, 20'h00ABC, 16'hBEEF, 1'b0);
    cap(-1);
    flip = 1'b0;
    chk("flip_rsp", tr_rsp, win(WLAT, WLAT));
    chk("flip_dqoe_vs_oe", tr_dqoe & ~tr_oe & 17'h1FFFE, 0);
`ifdef MRAM_WRITE_VERIFY_EN
    chk("flip_rdata", c_rd[WLAT], 16'hBEEE);
    chk("flip_err", c_err[WLAT], 1);
`else
    chk("flip_rdata", c_rd[WLAT], 16'hBEEF);
    chk("flip_err", c_err[WLAT], 0);
`endif

    // req_valid held high: inputs after accept ignored, next accept on edge 7
    issue(1'b0, 20'h00111, 16'h0000, 1'b1);
    bus.req_addr = 20'h00222;
    cap(8);
    bad_a = 0;
    for (int c = 1; c <= 7; c++) if (c_addr[c] != 20'h00111) bad_a++;
    chk("b2b_ready", tr_rdy, win(7, 7) | win(14, 16));
    chk("b2b_addr_ignored", bad_a, 0);
    chk("b2b_addr_second", c_addr[8], 20'h00222);
    chk("b2b_rsp", tr_rsp, win(6, 6) | win(13, 13));

    // Asynchronous reset in cycle 3 of a write
    issue(1'b1, 20'h00F00, 16'h1234, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_we_low", mram_we_n, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {mram_ce_n, mram_we_n, mram_oe_n, mram_lb_n, mram_ub_n}, 5'h1F);
    chk("mid_rst_dq_oe", mram_dq_oe, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cap(-1);
    chk("mid_rst_no_rsp", tr_rsp, 0);
    chk("mid_rst_ready", tr_rdy, 17'h1FFFE);

    // 2/4/2 instance read
    @(negedge clk);
    bus2.req_valid = 1'b1;
    bus2.req_write = 1'b0;
    bus2.req_addr  = 20'h00042;
    @(posedge clk);
    #1 bus2.req_valid = 1'b0;
    t2_oe = '0; t2_rsp = '0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      t2_oe[c]  = oe2;
      t2_rsp[c] = bus2.rsp_valid;
      if (c == 9) chk("p242_rdata", bus2.rsp_rdata, 16'h5A5A);
    end
    chk("p242_oe", t2_oe, low_in(3, 6));
    chk("p242_rsp", t2_rsp, win(9, 9));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
